// File: rtl/fifo_lifo_pkg.sv
// Shared constants and helpers for the FIFO/LIFO buffer family.
package fifo_lifo_pkg;

    localparam int unsigned MODE_FIFO = 0;
    localparam int unsigned MODE_LIFO = 1;

    // Count must represent 0..DEPTH inclusive, hence one bit beyond the address width.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_lifo_buffer_if.sv
// Producer/consumer bus of the FIFO/LIFO buffer; master drives requests, slave is the buffer.
interface fifo_lifo_buffer_if
    import fifo_lifo_pkg::*;
#(
    parameter int unsigned DAT_WIDTH = 32,
    parameter int unsigned DEPTH     = 64
);

    localparam int unsigned CW = cnt_width(DEPTH);

    logic                 Clr;
    logic [DAT_WIDTH-1:0] Datain;
    logic                 Wren;
    logic                 Rden;
    logic [DAT_WIDTH-1:0] Dataout;
    logic                 Dvalid;
    logic [CW-1:0]        Count;
    logic                 Full;
    logic                 Empty;
    logic                 Almost_full;
    logic                 Almost_empty;
    logic                 Overflow;
    logic                 Underflow;

    modport master (
        output Clr, Datain, Wren, Rden,
        input  Dataout, Dvalid, Count, Full, Empty,
        input  Almost_full, Almost_empty, Overflow, Underflow
    );

    modport slave (
        input  Clr, Datain, Wren, Rden,
        output Dataout, Dvalid, Count, Full, Empty,
        output Almost_full, Almost_empty, Overflow, Underflow
    );

endinterface

// File: rtl/fifo_lifo_ram.sv
// DEPTH x DAT_WIDTH storage: one synchronous write port, one registered read port.
module fifo_lifo_ram #(
    parameter int unsigned DAT_WIDTH = 32,
    parameter int unsigned DEPTH     = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
    input  logic [DAT_WIDTH-1:0]       i_wr_data,
    input  logic                       i_rd_en,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
    output logic [DAT_WIDTH-1:0]       o_rd_data
);

    logic [DAT_WIDTH-1:0] r_mem [DEPTH];
    logic [DAT_WIDTH-1:0] r_rd_data;

    // Contents are never reset; read-before-write gives old data on a same-address collision.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_lifo_buffer.sv
// Parametrised single-clock FIFO/LIFO buffer with occupancy, level flags and sticky error flags.
module fifo_lifo_buffer
    import fifo_lifo_pkg::*;
#(
    parameter int unsigned MODE      = MODE_FIFO,
    parameter int unsigned DAT_WIDTH = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned AF_LEVEL  = DEPTH - 2,
    parameter int unsigned AE_LEVEL  = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    fifo_lifo_buffer_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_lifo_buffer: DEPTH must be a power of two >= 2");
    end
    if ((AF_LEVEL > DEPTH) || (AE_LEVEL >= DEPTH)) begin : g_bad_levels
        $error("fifo_lifo_buffer: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");
    end

    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    logic                 r_udf;
    logic                 r_dvalid;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_rd_ok;
    logic                 w_wr_ok;
    logic                 w_rd_en;
    logic                 w_wr_en;
    logic [AW-1:0]        w_wr_addr;
    logic [AW-1:0]        w_rd_addr;
    logic [DAT_WIDTH-1:0] w_rd_data;

    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CW'(DEPTH));
        w_rd_ok = bus.Rden & ~w_empty;
        w_wr_ok = bus.Wren & (~w_full | w_rd_ok);
        w_rd_en = w_rd_ok & ~bus.Clr;
        w_wr_en = w_wr_ok & ~bus.Clr;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_dvalid <= 1'b0;
        end else if (bus.Clr) begin
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_dvalid <= 1'b0;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (bus.Wren & ~w_wr_ok) begin
                r_ovf <= 1'b1;
            end
            if (bus.Rden & w_empty) begin
                r_udf <= 1'b1;
            end
            r_dvalid <= w_rd_ok;
        end
    end

    if (MODE == MODE_FIFO) begin : g_fifo
        logic [AW-1:0] r_wr_ptr;
        logic [AW-1:0] r_rd_ptr;

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else if (bus.Clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_ok) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_rd_ok) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end

        assign w_wr_addr = r_wr_ptr;
        assign w_rd_addr = r_rd_ptr;
    end else begin : g_lifo
        // Count is the stack pointer; a pop+push replaces the top slot in place.
        logic [AW-1:0] w_top;

        assign w_top     = r_count[AW-1:0] - AW'(1);
        assign w_rd_addr = w_top;
        assign w_wr_addr = w_rd_ok ? w_top : r_count[AW-1:0];
    end

    fifo_lifo_ram #(
        .DAT_WIDTH (DAT_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .i_clk     (Clk),
        .i_rst_n   (Rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (bus.Datain),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign bus.Dataout      = w_rd_data;
    assign bus.Dvalid       = r_dvalid;
    assign bus.Count        = r_count;
    assign bus.Full         = w_full;
    assign bus.Empty        = w_empty;
    assign bus.Almost_full  = (r_count >= CW'(AF_LEVEL));
    assign bus.Almost_empty = (r_count <= CW'(AE_LEVEL));
    assign bus.Overflow     = r_ovf;
    assign bus.Underflow    = r_udf;

endmodule

// File: tb/tb_fifo_lifo_buffer.sv
// Drives a FIFO-mode and a LIFO-mode buffer with identical stimulus and checks both against queue models.
module tb_fifo_lifo_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFL   = 3;
    localparam int unsigned AEL   = 1;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          wren;
    logic          rden;
    logic [DW-1:0] din;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] qf[$];
    logic [DW-1:0] ql[$];
    logic [DW-1:0] m_dout_f;
    logic [DW-1:0] m_dout_l;
    logic          m_ovf;
    logic          m_udf;
    logic          m_dv;

    fifo_lifo_buffer_if #(.DAT_WIDTH(DW), .DEPTH(DEPTH)) if_f ();
    fifo_lifo_buffer_if #(.DAT_WIDTH(DW), .DEPTH(DEPTH)) if_l ();

    assign if_f.Clr    = clr;
    assign if_f.Wren   = wren;
    assign if_f.Rden   = rden;
    assign if_f.Datain = din;
    assign if_l.Clr    = clr;
    assign if_l.Wren   = wren;
    assign if_l.Rden   = rden;
    assign if_l.Datain = din;

    fifo_lifo_buffer #(
        .MODE(0), .DAT_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) u_fifo (
        .Clk(clk), .Rst_n(rst_n), .bus(if_f.slave)
    );

    fifo_lifo_buffer #(
        .MODE(1), .DAT_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) u_lifo (
        .Clk(clk), .Rst_n(rst_n), .bus(if_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("f_count",  32'(if_f.Count),        32'(qf.size()));
        chk("f_full",   32'(if_f.Full),         32'(qf.size() == DEPTH));
        chk("f_empty",  32'(if_f.Empty),        32'(qf.size() == 0));
        chk("f_afull",  32'(if_f.Almost_full),  32'(qf.size() >= AFL));
        chk("f_aempty", 32'(if_f.Almost_empty), 32'(qf.size() <= AEL));
        chk("f_ovf",    32'(if_f.Overflow),     32'(m_ovf));
        chk("f_udf",    32'(if_f.Underflow),    32'(m_udf));
        chk("f_dvalid", 32'(if_f.Dvalid),       32'(m_dv));
        chk("f_dout",   if_f.Dataout,           m_dout_f);
        chk("l_count",  32'(if_l.Count),        32'(ql.size()));
        chk("l_full",   32'(if_l.Full),         32'(ql.size() == DEPTH));
        chk("l_empty",  32'(if_l.Empty),        32'(ql.size() == 0));
        chk("l_afull",  32'(if_l.Almost_full),  32'(ql.size() >= AFL));
        chk("l_aempty", 32'(if_l.Almost_empty), 32'(ql.size() <= AEL));
        chk("l_ovf",    32'(if_l.Overflow),     32'(m_ovf));
        chk("l_udf",    32'(if_l.Underflow),    32'(m_udf));
        chk("l_dvalid", 32'(if_l.Dvalid),       32'(m_dv));
        chk("l_dout",   if_l.Dataout,           m_dout_l);
    endtask

    task automatic model_reset();
        qf.delete();
        ql.delete();
        m_dout_f = '0;
        m_dout_l = '0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_dv     = 1'b0;
    endtask

    task automatic model_update(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
        bit rd_ok;
        bit wr_ok;
        if (c) begin
            qf.delete();
            ql.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_dv  = 1'b0;
        end else begin
            rd_ok = r && (qf.size() > 0);
            wr_ok = w && ((qf.size() < DEPTH) || rd_ok);
            if (rd_ok) begin
                m_dout_f = qf.pop_front();
                m_dout_l = ql.pop_back();
            end
            if (wr_ok) begin
                qf.push_back(d);
                ql.push_back(d);
            end
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && !rd_ok) m_udf = 1'b1;
            m_dv = rd_ok;
        end
    endtask

    task automatic step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
        clr  = c;
        wren = w;
        rden = r;
        din  = d;
        @(posedge clk);
        #1;
        model_update(c, w, r, d);
        check_state();
        clr  = 1'b0;
        wren = 1'b0;
        rden = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        wren  = 1'b0;
        rden  = 1'b0;
        din   = '0;
        model_reset();
        #12;
        chk("rst_count", 32'(if_f.Count), 32'd0);
        chk("rst_empty", 32'(if_l.Empty), 32'd1);
        check_state();
        rst_n = 1'b1;

        // FIFO/LIFO order with full and almost-full boundaries
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'hA0 + 32'(i));
        chk("fill_full_f", 32'(if_f.Full), 32'd1);
        chk("fill_full_l", 32'(if_l.Full), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'hFF);
        chk("ovf_f", 32'(if_f.Overflow), 32'd1);
        chk("ovf_cnt", 32'(if_f.Count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            chk("ord_f", if_f.Dataout, 32'hA0 + 32'(i));
            chk("ord_l", if_l.Dataout, 32'hA3 - 32'(i));
        end
        chk("drain_empty", 32'(if_f.Empty), 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("udf_f", 32'(if_f.Underflow), 32'd1);
        chk("udf_dv", 32'(if_l.Dvalid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // simultaneous read/write while full
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'hA0 + 32'(i));
        step(1'b0, 1'b1, 1'b1, 32'hC0);
        chk("rw_full_f", if_f.Dataout, 32'hA0);
        chk("rw_full_l", if_l.Dataout, 32'hA3);
        chk("rw_full_cnt", 32'(if_l.Count), 32'd4);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("rw_top_l", if_l.Dataout, 32'hC0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("rw_last_f", if_f.Dataout, 32'hC0);

        // flush at Count=3 with Overflow set
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 32'hD0 + 32'(i));
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("pre_clr_ovf", 32'(if_f.Overflow), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'hEE);
        chk("clr_cnt", 32'(if_f.Count), 32'd0);
        chk("clr_ovf", 32'(if_l.Overflow), 32'd0);

        // asynchronous reset between edges while Count=2
        step(1'b0, 1'b1, 1'b0, 32'h11);
        step(1'b0, 1'b1, 1'b1, 32'h22);
        step(1'b0, 1'b1, 1'b0, 32'h33);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_cnt", 32'(if_f.Count), 32'd0);
        chk("arst_dout", if_l.Dataout, 32'd0);
        check_state();
        #2;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 32'h5A5A_0001);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("post_rst_f", if_f.Dataout, 32'h5A5A_0001);
        chk("post_rst_l", if_l.Dataout, 32'h5A5A_0001);

        // randomized traffic alternating between write-heavy and read-heavy phases
        for (int i = 0; i < 400; i++) begin
            logic c;
            logic w;
            logic r;
            c = ($urandom_range(0, 39) == 0);
            if (((i / 40) % 2) == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(c, w, r, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_lifo_buffer.md
# fifo_lifo_buffer

Parametrised single-clock FIFO/LIFO buffer, the next generation of the team's FIFO/LIFO block. Storage order is selected by MODE. Adds to the earlier block:
- generic width and depth;
- occupancy count;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- synchronous flush;
- a read-valid strobe.

It sits between a producer and a consumer in the same clock domain and is driven by the existing FIFO/LIFO scoreboard bench.

## Interface
- MODE, 0: storage order; 0 = FIFO, 1 = LIFO.
- DAT_WIDTH, 32: data width in bits, ≥1.
- DEPTH, 64: number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-2: Almost_full asserts when Count ≥ AF_LEVEL.
- AE_LEVEL, 2: Almost_empty asserts when Count ≤ AE_LEVEL.
- Clk  input  1  single clock, rising-edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Clr  input  1  synchronous flush; highest priority.
- Datain  input  DAT_WIDTH  write data.
- Wren  input  1  write request.
- Rden  input  1  read request.
- Dataout  output  DAT_WIDTH  read data (registered).
- Dvalid  output  1  one-cycle strobe: Dataout updated by an accepted read.
- Count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- Full  output  1  Count == DEPTH.
- Empty  output  1  Count == 0.
- Almost_full  output  1  Count ≥ AF_LEVEL.
- Almost_empty  output  1  Count ≤ AE_LEVEL.
- Overflow  output  1  sticky: a write was rejected.
- Underflow  output  1  sticky: a read was rejected.

## Operation
- **Flag decoding:** Full, Empty, Almost_full and Almost_empty are decoded from the registered Count only; no combinational path from Wren or Rden.
- **Read acceptance:** rd_ok = Rden & ~Empty.
- **Write acceptance:** wr_ok = Wren & (~Full | rd_ok). A write to a full buffer is accepted only when a read is accepted in the same cycle.
- **Rejected requests:**
  - Wren & ~wr_ok sets Overflow; the write is dropped.
  - Rden & Empty sets Underflow; Dataout holds and Dvalid stays 0.
  - The flags remain set until reset or Clr.
- **Count update:** Count += wr_ok − rd_ok.
- **FIFO mode (MODE=0):**
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Write stores mem[wr_ptr] and increments wr_ptr.
  - Read loads Dataout ← mem[rd_ptr] and increments rd_ptr.
  - With simultaneous accepted read and write, both happen and Count is unchanged.
- **LIFO mode (MODE=1):**
  - The stack pointer is Count.
  - Push stores mem[Count].
  - Pop loads Dataout ← mem[Count−1].
  - Simultaneous accepted pop+push (non-empty, including full): Dataout ← old mem[Count−1], then mem[Count−1] ← Datain; Count is unchanged.
  - On an empty buffer, push is accepted and pop is rejected (Underflow).
- **Flush (Clr=1):**
  - Pointers, Count, Overflow, Underflow and Dvalid go to 0.
  - Wren and Rden are ignored that cycle and no flags are set.
  - Memory contents and Dataout are retained.
- **Reset values (Rst_n=0):**
  - Count=0, Full=0, Empty=1, Almost_full=0, Almost_empty=1.
  - Dataout=0, Dvalid=0, Overflow=0, Underflow=0, pointers=0.
  - Memory is not reset.
  - Reset mid-operation discards all content immediately (asynchronous assertion); deassertion takes effect on the next Clk edge.

## Timing
- **Write-to-read latency:** data written at edge N is readable (Rden sampled) at edge N+1 and appears on Dataout after edge N+1.
- **Read latency:** 1 cycle. Dvalid is high for exactly the cycle after each accepted read; back-to-back reads give continuous Dvalid.
- **Status outputs:** Count and all flags update on the same edge as the accepted operation.
- **Sticky error flags:** Overflow and Underflow rise on the edge that samples the rejected request.
- **Throughput:** one write and one read per cycle, sustained, in both modes.

## Structure
- **Package fifo_lifo_pkg:**
  - MODE_FIFO=0 and MODE_LIFO=1 constants.
  - A count-width function, clog2(DEPTH)+1.
- **Sub-module fifo_lifo_ram:**
  - DEPTH×DAT_WIDTH storage.
  - One synchronous write port and one registered read port.
  - Parameters DAT_WIDTH and DEPTH.
- **Top module fifo_lifo_buffer:** holds pointer, count and flag control, plus the MODE generate branch.
- **Parameter check:** an elaboration-time check rejects a non-power-of-two DEPTH, and AF_LEVEL > DEPTH or AE_LEVEL ≥ DEPTH.

## Test plan
Directed scenarios use DAT_WIDTH=32, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
- **FIFO order:** MODE=0; write 0xA0..0xA3, then 4 reads.
  - Dataout 0xA0, 0xA1, 0xA2, 0xA3 with Dvalid each.
  - Full=1 after the 4th write; Empty=1 after the last read.
- **LIFO order:** MODE=1; push 0xB0..0xB3, then pop ×4.
  - Dataout 0xB3, 0xB2, 0xB1, 0xB0.
  - Almost_full=1 at Count=3; Almost_empty=1 at Count≤1.
- **Overflow and underflow:** write a 5th word 0xFF when full → Overflow=1, Count stays 4, and 0xFF is never read. Read 5 times → Underflow=1 on the 5th, Dvalid=0 on the 5th.
- **Simultaneous read/write at full:**
  - FIFO full with 0xA0..0xA3, Wren=Rden=1 with 0xC0 → Dataout=0xA0, Count=4; a subsequent drain yields 0xA1, 0xA2, 0xA3, 0xC0.
  - LIFO full, same stimulus → Dataout=0xB3, top becomes 0xC0.
- **Flush:** Count=3 with Overflow=1; assert Clr together with Wren=1 → next cycle Count=0, Empty=1, Overflow=0, and nothing is written.
- **Async reset mid-stream:** assert Rst_n=0 between Clk edges while Count=2.
  - All outputs go to their reset values immediately, without waiting for a Clk edge.
  - After release, the first write/read pair returns the new data with 1-cycle latency.
